// File: rtl/ifstage.sv
// Instruction fetch stage: holds the PC, requests words from instruction memory,
// keeps each fetched word until control consumes it, and retries fetches that time out.
module ifstage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PC_Sel,
    input  logic        PC_LdEn,
    input  logic [31:0] PC_Immed,
    input  logic [31:0] IMem_Rdata,
    input  logic        IMem_Ack,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    output logic        Fetch_Err
);

    localparam int             CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        RETRY = 2'b10
    } state_t;

    state_t        state_r;
    logic [31:0]   pc_r;
    logic [31:0]   instr_r;
    logic          valid_r;
    logic          err_r;
    logic          req_r;
    logic [CW-1:0] cnt_r;

    logic [31:0]   seq_pc_s;
    logic [31:0]   tgt_pc_s;
    logic [31:0]   next_pc_s;
    logic [CW-1:0] cnt_inc_s;

    // Next-PC candidates; the immediate counts words, so it is scaled by four.
    always_comb begin
        seq_pc_s  = pc_r + 32'd4;
        tgt_pc_s  = seq_pc_s + {PC_Immed[29:0], 2'b00};
        cnt_inc_s = cnt_r + CW'(1);
        if (PC_Sel) begin
            next_pc_s = tgt_pc_s;
        end else begin
            next_pc_s = seq_pc_s;
        end
    end

    // Fetch FSM with registered outputs. req_r is low in the first FETCH cycle after
    // reset, so that cycle issues the request rather than counting toward the timeout.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            req_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (!req_r) begin
                        req_r <= 1'b1;
                    end else if (IMem_Ack) begin
                        instr_r <= IMem_Rdata;
                        valid_r <= 1'b1;
                        req_r   <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= HOLD;
                    end else if (cnt_inc_s == TMO) begin
                        err_r   <= 1'b1;
                        req_r   <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= RETRY;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                HOLD: begin
                    if (PC_LdEn) begin
                        pc_r    <= next_pc_s;
                        valid_r <= 1'b0;
                        req_r   <= 1'b1;
                        state_r <= FETCH;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                RETRY: begin
                    req_r   <= 1'b1;
                    state_r <= FETCH;
                end
                default: begin
                    valid_r <= 1'b0;
                    req_r   <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= FETCH;
                end
            endcase
        end
    end

    assign IMem_Req    = req_r;
    assign IMem_Addr   = pc_r;
    assign PC          = pc_r;
    assign Instr       = instr_r;
    assign Instr_Valid = valid_r;
    assign Fetch_Err   = err_r;

endmodule

// File: tb/tb_ifstage.sv
// Directed bench for ifstage: sequential fetch, branches, timeout/retry,
// ack-at-timeout boundary, PC wrap and asynchronous reset mid-fetch.
module tb_ifstage;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        PC_Sel = 1'b0;
    logic        PC_LdEn = 1'b0;
    logic [31:0] PC_Immed = 32'h0;
    logic [31:0] IMem_Rdata = 32'h0;
    logic        IMem_Ack = 1'b0;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic        Fetch_Err;

    int n_cmp = 0;
    int n_err = 0;

    ifstage #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset), .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn),
        .PC_Immed(PC_Immed), .IMem_Rdata(IMem_Rdata), .IMem_Ack(IMem_Ack),
        .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .PC(PC), .Instr(Instr),
        .Instr_Valid(Instr_Valid), .Fetch_Err(Fetch_Err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Entered in a FETCH cycle with Req high; idles 'waits' cycles then acks.
    task automatic serve(input logic [31:0] addr, input int waits);
        chk("req_high", {31'h0, IMem_Req}, 32'h1);
        chk("fetch_addr", IMem_Addr, addr);
        for (int i = 0; i < waits; i++) tick();
        chk("addr_stable", IMem_Addr, addr);
        IMem_Ack = 1'b1;
        IMem_Rdata = mem(addr);
        tick();
        IMem_Ack = 1'b0;
        IMem_Rdata = 32'hDEAD_BEEF;
        chk("valid_set", {31'h0, Instr_Valid}, 32'h1);
        chk("instr", Instr, mem(addr));
        chk("req_low_hold", {31'h0, IMem_Req}, 32'h0);
    endtask

    // Entered in HOLD; consumes the instruction and checks the new PC.
    task automatic advance(input logic sel, input logic [31:0] imm, input logic [31:0] exp_pc);
        tick();
        chk("hold_stable", {31'h0, Instr_Valid}, 32'h1);
        PC_LdEn = 1'b1;
        PC_Sel = sel;
        PC_Immed = imm;
        tick();
        PC_LdEn = 1'b0;
        PC_Sel = 1'b0;
        chk("valid_clr", {31'h0, Instr_Valid}, 32'h0);
        chk("new_pc", PC, exp_pc);
        chk("new_addr", IMem_Addr, exp_pc);
    endtask

    initial begin
        IMem_Ack = 1'b1;
        IMem_Rdata = 32'h1234_5678;
        #12;
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_valid", {31'h0, Instr_Valid}, 32'h0);
        chk("rst_err", {31'h0, Fetch_Err}, 32'h0);
        chk("rst_req", {31'h0, IMem_Req}, 32'h0);
        IMem_Ack = 1'b0;
        #10;
        Reset = 1'b1;
        tick();
        chk("first_req", {31'h0, IMem_Req}, 32'h1);
        chk("first_addr", IMem_Addr, 32'h0);

        // Sequential fetch 0,4,8,12
        serve(32'h0, 2);  advance(1'b0, 32'h0, 32'h4);
        serve(32'h4, 2);  advance(1'b0, 32'h0, 32'h8);
        serve(32'h8, 2);  advance(1'b0, 32'h0, 32'hC);
        serve(32'hC, 2);  advance(1'b0, 32'h0, 32'h10);

        // Branches from 0x10: backward by 2 words, then forward by 3 words
        serve(32'h10, 1); advance(1'b1, 32'hFFFF_FFFE, 32'hC);
        serve(32'hC, 0);  advance(1'b0, 32'h0, 32'h10);
        serve(32'h10, 0); advance(1'b1, 32'h0000_0003, 32'h20);
        serve(32'h20, 0);

        // Ack ignored in HOLD
        IMem_Ack = 1'b1;
        IMem_Rdata = 32'hBAD0_BAD0;
        tick();
        IMem_Ack = 1'b0;
        chk("hold_ack_ign", Instr, mem(32'h20));
        advance(1'b0, 32'h0, 32'h24);

        // Ack on exactly the TIMEOUT-th cycle wins
        serve(32'h24, 14);
        chk("bound_no_err", {31'h0, Fetch_Err}, 32'h0);
        advance(1'b0, 32'h0, 32'h28);

        // PC_LdEn ignored in FETCH (these two cycles count toward the timeout)
        PC_LdEn = 1'b1;
        PC_Sel = 1'b1;
        PC_Immed = 32'h5;
        tick();
        tick();
        PC_LdEn = 1'b0;
        PC_Sel = 1'b0;
        chk("ldEn_fetch_pc", PC, 32'h28);

        // Timeout: cycles 3..14 without ack, expiry at cycle 15
        for (int i = 0; i < 12; i++) tick();
        chk("pre_to_req", {31'h0, IMem_Req}, 32'h1);
        chk("pre_to_err", {31'h0, Fetch_Err}, 32'h0);
        tick();
        chk("to_err", {31'h0, Fetch_Err}, 32'h1);
        chk("retry_req", {31'h0, IMem_Req}, 32'h0);
        chk("retry_pc", PC, 32'h28);
        tick();
        chk("refetch_req", {31'h0, IMem_Req}, 32'h1);
        serve(32'h28, 1);
        chk("err_sticky", {31'h0, Fetch_Err}, 32'h1);

        // Branch to the top word, then wrap to 0
        advance(1'b1, 32'hFFFF_FFF4, 32'hFFFF_FFFC);
        serve(32'hFFFF_FFFC, 0);
        advance(1'b0, 32'h0, 32'h0);
        serve(32'h0, 0);
        advance(1'b0, 32'h0, 32'h4);

        // Asynchronous reset during FETCH with Ack high
        IMem_Ack = 1'b1;
        IMem_Rdata = mem(32'h4);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_pc", PC, 32'h0);
        chk("arst_instr", Instr, 32'h0);
        chk("arst_err", {31'h0, Fetch_Err}, 32'h0);
        chk("arst_req", {31'h0, IMem_Req}, 32'h0);
        chk("arst_valid", {31'h0, Instr_Valid}, 32'h0);
        tick();
        chk("arst_hold_instr", Instr, 32'h0);
        IMem_Ack = 1'b0;
        Reset = 1'b1;
        tick();
        serve(32'h0, 2);
        chk("restart_err", {31'h0, Fetch_Err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifstage.md
IFSTAGE -- requirements
Module: ifstage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 15: number of FETCH cycles without IMem_Ack before a retry.
REQ-003 Clk  in  1  single clock; all state changes on the rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 PC_Sel  in  1  next-PC select from control: 0 = PC+4, 1 = branch target.
REQ-006 PC_LdEn  in  1  advance strobe from control: the current instruction is consumed.
REQ-007 PC_Immed  in  32  sign-extended branch immediate, in words.
REQ-008 IMem_Rdata  in  32  instruction word returned by instruction memory.
REQ-009 IMem_Ack  in  1  instruction memory response valid; IMem_Rdata is valid in the same cycle.
REQ-010 IMem_Req  out  1  fetch request to instruction memory.
REQ-011 IMem_Addr  out  32  fetch byte address; always equal to PC.
REQ-012 PC  out  32  current program counter.
REQ-013 Instr  out  32  held instruction word, driven to the control unit and the decode stage.
REQ-014 Instr_Valid  out  1  Instr holds the word fetched from the current PC.
REQ-015 Fetch_Err  out  1  sticky flag: at least one fetch timed out.

Function
REQ-016 The FSM SHALL have three states: FETCH (IMem_Req=1), HOLD (Instr_Valid=1, IMem_Req=0) and RETRY (IMem_Req=0, one cycle only).
REQ-017 In FETCH, on IMem_Ack=1 the block SHALL register IMem_Rdata into Instr, set Instr_Valid=1 and enter HOLD on the same edge (one-cycle latency from Ack to Instr_Valid).
REQ-018 In FETCH, the wait counter SHALL increment each cycle without Ack; when it equals TIMEOUT with no Ack, the block SHALL set Fetch_Err=1, clear the counter and enter RETRY.
REQ-019 From RETRY the block SHALL return to FETCH on the next edge with PC unchanged.
REQ-020 In HOLD, Instr SHALL remain stable until PC_LdEn=1.
REQ-021 In HOLD with PC_LdEn=1, the block SHALL load PC with PC+4 if PC_Sel=0, or PC+4+(PC_Immed<<2) if PC_Sel=1; it SHALL also clear Instr_Valid and enter FETCH on the same edge.
REQ-022 All PC arithmetic SHALL be unsigned modulo 2^32: 32'hFFFF_FFFC+4 gives 0, and negative PC_Immed branches backward.
REQ-023 PC[1:0] SHALL stay at 00 after reset as long as RESET_PC is word-aligned.
REQ-024 PC_LdEn SHALL be ignored in FETCH and RETRY, so no PC change can occur without a valid instruction.
REQ-025 IMem_Ack SHALL be ignored in HOLD and RETRY; Instr SHALL be unchanged.
REQ-026 If IMem_Ack arrives in the same cycle the counter reaches TIMEOUT, the Ack SHALL win: Instr is captured, Fetch_Err is not set and the next state is HOLD.
REQ-027 IMem_Addr SHALL be driven from the PC register, not from next-PC logic; it SHALL be stable for the whole FETCH interval.
REQ-028 Fetch_Err SHALL be cleared only by Reset.

Reset
REQ-029 While Reset=0, the block SHALL hold PC=RESET_PC, Instr=0, Instr_Valid=0, Fetch_Err=0, counter=0 and state=FETCH; IMem_Req SHALL be 0 during reset.
REQ-030 On the first rising edge after Reset deasserts, IMem_Req SHALL be 1 with IMem_Addr=RESET_PC.
REQ-031 Reset asserted mid-fetch or in HOLD SHALL abort immediately and asynchronously, discarding any Ack in the same cycle.

Verification
REQ-032 Sequential: release reset, with Ack 2 cycles after each Req and PC_LdEn=1 PC_Sel=0 one cycle after Instr_Valid -> IMem_Addr sequence 0,4,8,12; Instr matches each memory word.
REQ-033 Branch: in HOLD at PC=0x10, PC_Sel=1, PC_Immed=32'hFFFF_FFFE, PC_LdEn=1 -> next IMem_Addr=0x0C; with PC_Immed=3 -> 0x20.
REQ-034 Timeout: no Ack for TIMEOUT cycles -> Fetch_Err=1, IMem_Req low 1 cycle, then re-request at the same address; a later Ack is captured normally.
REQ-035 Boundaries: Ack on exactly cycle TIMEOUT -> no Fetch_Err, Instr captured; PC_LdEn pulsed during FETCH -> PC unchanged; PC=32'hFFFF_FFFC with sequential advance -> PC=0.
REQ-036 Reset mid-operation: assert Reset during FETCH with Ack high -> outputs return to reset values immediately, Instr=0, Fetch_Err=0; fetch restarts at RESET_PC.
